rat_arf_mw: RTL and testbench
=============================

RAT_ARF_MW -- requirements
Module: rat_arf_mw

Interface
REQ-001 SHALL have parameter NUM_REGS, default 32, architectural register count (power of 2, AW = log2(NUM_REGS)).
REQ-002 SHALL have parameter XLEN, default 32, register data width.
REQ-003 SHALL have parameter ROB_IDX_WIDTH, default 5, ROB tag width.
REQ-004 SHALL have parameter DISP_W, default 2, rename slots per cycle (slot 0 oldest).
REQ-005 SHALL have parameter COMMIT_W, default 2, commit ports per cycle (port 0 oldest).
REQ-006 SHALL have: clk  input  1  clock, all state on rising edge.
REQ-007 SHALL have: rst  input  1  asynchronous, active-low reset.
REQ-008 SHALL have: disp_valid  input  DISP_W  per-slot rename request.
REQ-009 SHALL have: disp_rs1_addr  input  DISP_W*AW  source 1 register per slot.
REQ-010 SHALL have: disp_rs2_addr  input  DISP_W*AW  source 2 register per slot.
REQ-011 SHALL have: disp_rd_addr  input  DISP_W*AW  destination register per slot.
REQ-012 SHALL have: disp_rob_idx  input  DISP_W*ROB_IDX_WIDTH  ROB tag allocated per slot.
REQ-013 SHALL have: commit_valid  input  COMMIT_W  per-port register write at commit.
REQ-014 SHALL have: commit_rd_addr / commit_rob_idx / commit_data  input  COMMIT_W*AW / COMMIT_W*ROB_IDX_WIDTH / COMMIT_W*XLEN  committed destination, tag, value.
REQ-015 SHALL have: flush  input  1  pipeline flush; discard all speculative mappings.
REQ-016 SHALL have: src_rdy  output  DISP_W*2  per slot {rs2,rs1} value in ARF.
REQ-017 SHALL have: src_rob_idx  output  DISP_W*2*ROB_IDX_WIDTH  producer tag when not ready.
REQ-018 SHALL have: src_data  output  DISP_W*2*XLEN  ARF value when ready.

Function
REQ-019 Per-entry state SHALL be {data, ready, rob_idx}; register 0 SHALL read ready=1, data=0, rob_idx=0 and never be written.
REQ-020 Source lookup SHALL be combinational from current table state (zero latency).
REQ-021 Intra-group rename: slot j source matching rd of valid slot i<j (rd!=0) SHALL return rdy=0, rob_idx of the youngest such i.
REQ-022 On valid rename (rd!=0, no flush) entry SHALL update next edge: ready=0, rob_idx=disp_rob_idx; multiple slots same rd -> highest slot wins.
REQ-023 On commit port k (rd!=0) data SHALL be written; ready SHALL set to 1 only if entry rob_idx equals commit_rob_idx and no same-cycle rename targets that rd.
REQ-024 Multiple commit ports same rd SHALL apply highest port last (its data and tag compare win).
REQ-025 Rename and commit to same rd same cycle: data written, ready=0, rob_idx=new tag.
REQ-026 On flush: all ready SHALL set to 1, commit writes that cycle SHALL still apply, renames that cycle SHALL be ignored.
REQ-027 No counters; ready tracking SHALL rely solely on tag match (REQ-023).

Reset
REQ-028 While rst=0, all entries SHALL be data=0, ready=1, rob_idx=0 immediately (async), so src_rdy=all ones, src_data=0, src_rob_idx=0; release SHALL be synchronised by the instantiating logic.

Configuration
REQ-029 Macro RAT_ARF_MW_COMMIT_BYPASS_EN defined: source whose entry would become ready this cycle per REQ-023 SHALL return rdy=1 and commit_data combinationally, intra-group rename (REQ-021) still taking priority; undefined: lookup sees only registered state.

Structure
REQ-030 Entry typedef rat_arf_mw_entry_t and default widths SHALL live in rv32i_types.
REQ-031 Per-source lookup (table read, intra-group check, optional bypass) SHALL be sub-module rat_src_lookup, instantiated 2*DISP_W times.

Verification
REQ-032 Reset then read x5 -> rdy=1, data=0; rename x5 tag 3, next cycle read x5 -> rdy=0, rob_idx=3.
REQ-033 Slot0 rd=x7 tag 4, slot1 rs1=x7 same cycle -> slot1 rdy=0, rob_idx=4.
REQ-034 x9 renamed tag 2 then tag 6; commit x9 tag 2 data 0xAA -> data=0xAA, rdy=0, rob_idx=6; commit tag 6 data 0xBB -> rdy=1, data=0xBB.
REQ-035 Rename x3 tag 1, flush with commit x4 data 0x55 -> all rdy=1, x4=0x55, x3 rob_idx unchanged by flushed rename.
REQ-036 Commit x2 tag 5 data 0x11 with x2 tag 5 pending, same-cycle read x2 -> bypass on: rdy=1, data=0x11; off: rdy=0, rob_idx=5.
REQ-037 Write to x0 via rename and commit -> x0 reads rdy=1, data=0 always; rst asserted mid-rename -> table returns to reset values without clock edge.

Source files
------------

// File: rtl/rat_arf_mw_pkg.sv
// rv32i_types: shared default widths and the rename/architectural register
// table entry type used by rat_arf_mw and its source lookup sub-module.
// Entry field widths are fixed to the default XLEN / ROB_IDX_WIDTH; the
// table logic casts to and from the instance parameters.
package rv32i_types;

    localparam int RV_NUM_REGS      = 32;
    localparam int RV_XLEN          = 32;
    localparam int RV_ROB_IDX_WIDTH = 5;

    typedef struct packed {
        logic [RV_XLEN-1:0]          data;
        logic                        ready;
        logic [RV_ROB_IDX_WIDTH-1:0] rob_idx;
    } rat_arf_mw_entry_t;

    // Value of every entry out of reset and the permanent value of x0.
    localparam rat_arf_mw_entry_t ENTRY_RESET = '{data: '0, ready: 1'b1, rob_idx: '0};

endpackage

// File: rtl/rat_arf_mw_if.sv
// rat_arf_mw_if: dispatch, commit, flush and source-lookup signals of the
// rename table. Master drives requests, slave (the table) answers lookups.
interface rat_arf_mw_if #(
    parameter int NUM_REGS      = 32,
    parameter int XLEN          = 32,
    parameter int ROB_IDX_WIDTH = 5,
    parameter int DISP_W        = 2,
    parameter int COMMIT_W      = 2
);
    localparam int AW = $clog2(NUM_REGS);

    logic [DISP_W-1:0]                 disp_valid;
    logic [DISP_W*AW-1:0]              disp_rs1_addr;
    logic [DISP_W*AW-1:0]              disp_rs2_addr;
    logic [DISP_W*AW-1:0]              disp_rd_addr;
    logic [DISP_W*ROB_IDX_WIDTH-1:0]   disp_rob_idx;
    logic [COMMIT_W-1:0]               commit_valid;
    logic [COMMIT_W*AW-1:0]            commit_rd_addr;
    logic [COMMIT_W*ROB_IDX_WIDTH-1:0] commit_rob_idx;
    logic [COMMIT_W*XLEN-1:0]          commit_data;
    logic                              flush;
    logic [DISP_W*2-1:0]               src_rdy;
    logic [DISP_W*2*ROB_IDX_WIDTH-1:0] src_rob_idx;
    logic [DISP_W*2*XLEN-1:0]          src_data;

    modport master (
        output disp_valid, disp_rs1_addr, disp_rs2_addr, disp_rd_addr, disp_rob_idx,
        output commit_valid, commit_rd_addr, commit_rob_idx, commit_data, flush,
        input  src_rdy, src_rob_idx, src_data
    );

    modport slave (
        input  disp_valid, disp_rs1_addr, disp_rs2_addr, disp_rd_addr, disp_rob_idx,
        input  commit_valid, commit_rd_addr, commit_rob_idx, commit_data, flush,
        output src_rdy, src_rob_idx, src_data
    );

endinterface

// File: rtl/rat_arf_mw_src_lookup.sv
// rat_src_lookup: one source operand lookup. Reads the table entry, applies
// the optional commit bypass (RAT_ARF_MW_COMMIT_BYPASS_EN) and then lets an
// older slot in the same dispatch group that writes this register override it.
module rat_src_lookup
    import rv32i_types::*;
#(
    parameter int NUM_REGS      = 32,
    parameter int XLEN          = 32,
    parameter int ROB_IDX_WIDTH = 5,
    parameter int DISP_W        = 2,
    parameter int SLOT          = 0,
    parameter int AW            = $clog2(NUM_REGS)
) (
    input  logic [AW-1:0]                       i_addr,
    input  rat_arf_mw_entry_t [NUM_REGS-1:0]    i_tbl,
`ifdef RAT_ARF_MW_COMMIT_BYPASS_EN
    input  logic [NUM_REGS-1:0]                 i_byp_vld,
    input  logic [NUM_REGS*XLEN-1:0]            i_byp_data,
`endif
    input  logic [DISP_W-1:0]                   i_disp_valid,
    input  logic [DISP_W*AW-1:0]                i_disp_rd,
    input  logic [DISP_W*ROB_IDX_WIDTH-1:0]     i_disp_rob,
    output logic                                o_rdy,
    output logic [ROB_IDX_WIDTH-1:0]            o_rob_idx,
    output logic [XLEN-1:0]                     o_data
);
    rat_arf_mw_entry_t w_ent;

    // Table read, then bypass, then intra-group rename (youngest older slot wins).
    always_comb begin
        w_ent     = i_tbl[i_addr];
        o_rdy     = w_ent.ready;
        o_rob_idx = ROB_IDX_WIDTH'(w_ent.rob_idx);
        o_data    = XLEN'(w_ent.data);
`ifdef RAT_ARF_MW_COMMIT_BYPASS_EN
        if (i_byp_vld[i_addr]) begin
            o_rdy  = 1'b1;
            o_data = i_byp_data[int'(i_addr)*XLEN +: XLEN];
        end
`endif
        for (int i = 0; i < DISP_W; i++) begin
            if ((i < SLOT) && i_disp_valid[i] && (i_disp_rd[i*AW +: AW] == i_addr)
                && (i_addr != '0)) begin
                o_rdy     = 1'b0;
                o_rob_idx = i_disp_rob[i*ROB_IDX_WIDTH +: ROB_IDX_WIDTH];
            end
        end
    end

endmodule

// File: rtl/rat_arf_mw.sv
// rat_arf_mw: combined rename table / architectural register file with
// DISP_W rename slots and COMMIT_W commit ports. Readiness is tracked purely
// by producer-tag match at commit. Optional feature macro:
// RAT_ARF_MW_COMMIT_BYPASS_EN forwards a same-cycle completing commit to lookups.
module rat_arf_mw
    import rv32i_types::*;
#(
    parameter int NUM_REGS      = RV_NUM_REGS,
    parameter int XLEN          = RV_XLEN,
    parameter int ROB_IDX_WIDTH = RV_ROB_IDX_WIDTH,
    parameter int DISP_W        = 2,
    parameter int COMMIT_W      = 2
) (
    input  logic         clk,
    input  logic         rst,
    rat_arf_mw_if.slave  bus
);
    localparam int AW = $clog2(NUM_REGS);

    rat_arf_mw_entry_t [NUM_REGS-1:0]     w_tbl;
    logic [DISP_W*2-1:0]                  w_src_rdy;
    logic [DISP_W*2*ROB_IDX_WIDTH-1:0]    w_src_rob;
    logic [DISP_W*2*XLEN-1:0]             w_src_data;
`ifdef RAT_ARF_MW_COMMIT_BYPASS_EN
    logic [NUM_REGS-1:0]                  w_byp_vld;
    logic [NUM_REGS*XLEN-1:0]             w_byp_data;
`endif

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_entry
        if (gi == 0) begin : g_zero
            // x0 is hard-wired: always ready with value zero.
            assign w_tbl[gi] = ENTRY_RESET;
`ifdef RAT_ARF_MW_COMMIT_BYPASS_EN
            assign w_byp_vld[gi]               = 1'b0;
            assign w_byp_data[gi*XLEN +: XLEN] = '0;
`endif
        end else begin : g_reg
            localparam logic [AW-1:0] IDX = AW'(gi);
            rat_arf_mw_entry_t         r_entry;
            rat_arf_mw_entry_t         w_next;
            logic                      w_cm_hit;
            logic                      w_cm_tag_eq;
            logic [RV_XLEN-1:0]        w_cm_data;
            logic                      w_rn_hit;
            logic [RV_ROB_IDX_WIDTH-1:0] w_rn_tag;
            logic                      w_becomes_rdy;

            // Decode commit ports (highest port last) and renames (highest slot last).
            always_comb begin
                w_cm_hit    = 1'b0;
                w_cm_tag_eq = 1'b0;
                w_cm_data   = r_entry.data;
                w_rn_hit    = 1'b0;
                w_rn_tag    = r_entry.rob_idx;
                for (int k = 0; k < COMMIT_W; k++) begin
                    if (bus.commit_valid[k] && (bus.commit_rd_addr[k*AW +: AW] == IDX)) begin
                        w_cm_hit    = 1'b1;
                        w_cm_data   = RV_XLEN'(bus.commit_data[k*XLEN +: XLEN]);
                        w_cm_tag_eq = (r_entry.rob_idx ==
                                       RV_ROB_IDX_WIDTH'(bus.commit_rob_idx[k*ROB_IDX_WIDTH +: ROB_IDX_WIDTH]));
                    end
                end
                for (int s = 0; s < DISP_W; s++) begin
                    if (bus.disp_valid[s] && (bus.disp_rd_addr[s*AW +: AW] == IDX)) begin
                        w_rn_hit = 1'b1;
                        w_rn_tag = RV_ROB_IDX_WIDTH'(bus.disp_rob_idx[s*ROB_IDX_WIDTH +: ROB_IDX_WIDTH]);
                    end
                end
                // A flush discards the renames presented alongside it.
                if (bus.flush) begin
                    w_rn_hit = 1'b0;
                end
            end

            assign w_becomes_rdy = w_cm_hit & w_cm_tag_eq & ~w_rn_hit;

            // Next entry value: commit data, then tag-matched ready, rename, flush.
            always_comb begin
                w_next      = r_entry;
                w_next.data = w_cm_data;
                if (w_becomes_rdy) begin
                    w_next.ready = 1'b1;
                end
                if (w_rn_hit) begin
                    w_next.ready   = 1'b0;
                    w_next.rob_idx = w_rn_tag;
                end
                if (bus.flush) begin
                    w_next.ready = 1'b1;
                end
            end

            // Entry storage with asynchronous active-low clear.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_entry <= ENTRY_RESET;
                end else begin
                    r_entry <= w_next;
                end
            end

            assign w_tbl[gi] = r_entry;
`ifdef RAT_ARF_MW_COMMIT_BYPASS_EN
            assign w_byp_vld[gi]               = w_becomes_rdy;
            assign w_byp_data[gi*XLEN +: XLEN] = XLEN'(w_cm_data);
`endif
        end
    end

    for (genvar gi = 0; gi < 2*DISP_W; gi++) begin : g_src
        localparam int SLOT = gi / 2;
        logic [AW-1:0] w_addr;

        if (gi % 2 == 0) begin : g_rs1
            assign w_addr = bus.disp_rs1_addr[SLOT*AW +: AW];
        end else begin : g_rs2
            assign w_addr = bus.disp_rs2_addr[SLOT*AW +: AW];
        end

        rat_src_lookup #(
            .NUM_REGS      (NUM_REGS),
            .XLEN          (XLEN),
            .ROB_IDX_WIDTH (ROB_IDX_WIDTH),
            .DISP_W        (DISP_W),
            .SLOT          (SLOT),
            .AW            (AW)
        ) u_lookup (
            .i_addr        (w_addr),
            .i_tbl         (w_tbl),
`ifdef RAT_ARF_MW_COMMIT_BYPASS_EN
            .i_byp_vld     (w_byp_vld),
            .i_byp_data    (w_byp_data),
`endif
            .i_disp_valid  (bus.disp_valid),
            .i_disp_rd     (bus.disp_rd_addr),
            .i_disp_rob    (bus.disp_rob_idx),
            .o_rdy         (w_src_rdy[gi]),
            .o_rob_idx     (w_src_rob[gi*ROB_IDX_WIDTH +: ROB_IDX_WIDTH]),
            .o_data        (w_src_data[gi*XLEN +: XLEN])
        );
    end

    assign bus.src_rdy     = w_src_rdy;
    assign bus.src_rob_idx = w_src_rob;
    assign bus.src_data    = w_src_data;

endmodule

// File: tb/tb_rat_arf_mw.sv
// tb_rat_arf_mw: directed scenarios followed by random traffic. Each cycle the
// driver predicts all source lookups from a behavioural register-table model
// and queues them; a negedge monitor pops and compares against the DUT.
module tb_rat_arf_mw;
    localparam int NR = 32;
    localparam int XL = 32;
    localparam int TW = 5;
    localparam int DW = 2;
    localparam int CW = 2;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    rat_arf_mw_if #(.NUM_REGS(NR), .XLEN(XL), .ROB_IDX_WIDTH(TW), .DISP_W(DW), .COMMIT_W(CW)) bus_if ();

    rat_arf_mw #(.NUM_REGS(NR), .XLEN(XL), .ROB_IDX_WIDTH(TW), .DISP_W(DW), .COMMIT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Per-cycle stimulus
    logic          d_valid [DW];
    logic [AW-1:0] d_rs1   [DW];
    logic [AW-1:0] d_rs2   [DW];
    logic [AW-1:0] d_rd    [DW];
    logic [TW-1:0] d_tag   [DW];
    logic          c_valid [CW];
    logic [AW-1:0] c_rd    [CW];
    logic [TW-1:0] c_tag   [CW];
    logic [XL-1:0] c_data  [CW];
    logic          f;

    // Reference model: architectural state of every register
    logic [XL-1:0] m_data [NR];
    logic          m_rdy  [NR];
    logic [TW-1:0] m_tag  [NR];

    typedef struct {
        int                   id;
        logic [3:0]           rdy;
        logic [3:0][TW-1:0]   tag;
        logic [3:0][XL-1:0]   data;
    } exp_t;
    exp_t sb_q[$];

    function automatic void model_reset();
        for (int r = 0; r < NR; r++) begin
            m_data[r] = '0;
            m_rdy[r]  = 1'b1;
            m_tag[r]  = '0;
        end
    endfunction

    // Register state after the clock edge, derived from the table rules.
    function automatic void model_update();
        logic [TW-1:0] old_tag [NR];
        logic          hit     [NR];
        logic          match   [NR];
        logic          ren     [NR];
        logic [TW-1:0] ntag    [NR];
        for (int r = 0; r < NR; r++) begin
            old_tag[r] = m_tag[r];
            hit[r] = 1'b0; match[r] = 1'b0; ren[r] = 1'b0; ntag[r] = '0;
        end
        for (int k = 0; k < CW; k++) begin
            if (c_valid[k] && c_rd[k] != 0) begin
                m_data[c_rd[k]] = c_data[k];
                hit[c_rd[k]]    = 1'b1;
                match[c_rd[k]]  = (old_tag[c_rd[k]] == c_tag[k]);
            end
        end
        if (!f) begin
            for (int s = 0; s < DW; s++) begin
                if (d_valid[s] && d_rd[s] != 0) begin
                    ren[d_rd[s]]  = 1'b1;
                    ntag[d_rd[s]] = d_tag[s];
                end
            end
        end
        for (int r = 1; r < NR; r++) begin
            if (hit[r] && match[r] && !ren[r]) m_rdy[r] = 1'b1;
            if (ren[r]) begin
                m_rdy[r] = 1'b0;
                m_tag[r] = ntag[r];
            end
            if (f) m_rdy[r] = 1'b1;
        end
    endfunction

`ifdef RAT_ARF_MW_COMMIT_BYPASS_EN
    // True when register a completes this cycle (last matching commit port wins).
    function automatic logic will_ready(input logic [AW-1:0] a);
        logic h = 1'b0;
        logic m = 1'b0;
        if (a == 0) return 1'b0;
        for (int k = 0; k < CW; k++) begin
            if (c_valid[k] && c_rd[k] == a) begin
                h = 1'b1;
                m = (m_tag[a] == c_tag[k]);
            end
        end
        for (int s = 0; s < DW; s++) begin
            if (!f && d_valid[s] && d_rd[s] == a) return 1'b0;
        end
        return h && m;
    endfunction

    function automatic logic [XL-1:0] byp_data(input logic [AW-1:0] a);
        logic [XL-1:0] d = '0;
        for (int k = 0; k < CW; k++) begin
            if (c_valid[k] && c_rd[k] == a) d = c_data[k];
        end
        return d;
    endfunction
`endif

    function automatic void predict(output exp_t e);
        logic [AW-1:0] a;
        int            q;
        e.id = cyc; e.rdy = '0; e.tag = '0; e.data = '0;
        for (int s = 0; s < DW; s++) begin
            for (int k = 0; k < 2; k++) begin
                q = 2*s + k;
                a = (k == 0) ? d_rs1[s] : d_rs2[s];
                e.rdy[q]  = m_rdy[a];
                e.tag[q]  = m_tag[a];
                e.data[q] = m_data[a];
`ifdef RAT_ARF_MW_COMMIT_BYPASS_EN
                if (will_ready(a)) begin
                    e.rdy[q]  = 1'b1;
                    e.data[q] = byp_data(a);
                end
`endif
                for (int i = 0; i < s; i++) begin
                    if (d_valid[i] && d_rd[i] == a && a != 0) begin
                        e.rdy[q] = 1'b0;
                        e.tag[q] = d_tag[i];
                    end
                end
            end
        end
    endfunction

    task automatic clear_in();
        for (int s = 0; s < DW; s++) begin
            d_valid[s] = 1'b0; d_rs1[s] = '0; d_rs2[s] = '0; d_rd[s] = '0; d_tag[s] = '0;
        end
        for (int k = 0; k < CW; k++) begin
            c_valid[k] = 1'b0; c_rd[k] = '0; c_tag[k] = '0; c_data[k] = '0;
        end
        f = 1'b0;
    endtask

    task automatic drive_bus();
        for (int s = 0; s < DW; s++) begin
            bus_if.disp_valid[s]                = d_valid[s];
            bus_if.disp_rs1_addr[s*AW +: AW]    = d_rs1[s];
            bus_if.disp_rs2_addr[s*AW +: AW]    = d_rs2[s];
            bus_if.disp_rd_addr[s*AW +: AW]     = d_rd[s];
            bus_if.disp_rob_idx[s*TW +: TW]     = d_tag[s];
        end
        for (int k = 0; k < CW; k++) begin
            bus_if.commit_valid[k]              = c_valid[k];
            bus_if.commit_rd_addr[k*AW +: AW]   = c_rd[k];
            bus_if.commit_rob_idx[k*TW +: TW]   = c_tag[k];
            bus_if.commit_data[k*XL +: XL]      = c_data[k];
        end
        bus_if.flush = f;
    endtask

    // One cycle: drive, predict, queue, advance the model, wait for the edge.
    task automatic step();
        exp_t e;
        drive_bus();
        if (!rst) model_reset();
        predict(e);
        sb_q.push_back(e);
        if (rst) model_update();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Monitor: compare the four source lookups mid-cycle.
    always @(negedge clk) begin : monitor
        exp_t          e;
        logic          g_rdy;
        logic [TW-1:0] g_tag;
        logic [XL-1:0] g_data;
        int            bad;
        if (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            bad = 0;
            for (int q = 0; q < 4; q++) begin
                g_rdy  = bus_if.src_rdy[q];
                g_tag  = bus_if.src_rob_idx[q*TW +: TW];
                g_data = bus_if.src_data[q*XL +: XL];
                n_tests++;
                if ((g_rdy !== e.rdy[q]) ||
                    (e.rdy[q] ? (g_data !== e.data[q]) : (g_tag !== e.tag[q]))) begin
                    n_fail++;
                    bad++;
                    $display("FAIL src%0d cyc%0d: got rdy=%0d tag=%0d data=%h, expected rdy=%0d tag=%0d data=%h",
                             q, e.id, g_rdy, g_tag, g_data, e.rdy[q], e.tag[q], e.data[q]);
                end
            end
            if (bad == 0) $display("[TB] cyc %0d lookups ok rdy=%b", e.id, e.rdy);
        end
    end

    initial begin
        model_reset();
        clear_in();
        drive_bus();
        @(posedge clk);
        #1;

        // Reset held: lookups see reset values
        clear_in(); d_rs1[0] = 5; d_rs2[0] = 9; step();
        clear_in(); d_rs1[1] = 5; step();
        rst = 1'b1;

        // Read x5, rename x5 tag 3, read again
        clear_in(); d_rs1[0] = 5; step();
        clear_in(); d_valid[0] = 1; d_rd[0] = 5; d_tag[0] = 3; d_rs1[0] = 5; step();
        clear_in(); d_rs1[0] = 5; step();

        // Intra-group: slot0 writes x7, slot1 reads x7
        clear_in(); d_valid[0] = 1; d_rd[0] = 7; d_tag[0] = 4; d_rs1[1] = 7; step();

        // Stale commit vs. newest tag on x9
        clear_in(); d_valid[0] = 1; d_rd[0] = 9; d_tag[0] = 2; step();
        clear_in(); d_valid[1] = 1; d_rd[1] = 9; d_tag[1] = 6; d_rs1[0] = 9; step();
        clear_in(); c_valid[0] = 1; c_rd[0] = 9; c_tag[0] = 2; c_data[0] = 32'hAA; d_rs1[0] = 9; step();
        clear_in(); d_rs1[0] = 9; d_rs2[1] = 9; step();
        clear_in(); c_valid[1] = 1; c_rd[1] = 9; c_tag[1] = 6; c_data[1] = 32'hBB; d_rs1[0] = 9; step();
        clear_in(); d_rs1[0] = 9; step();

        // Flush with a rename and a commit in the same cycle
        clear_in(); d_valid[0] = 1; d_rd[0] = 3; d_tag[0] = 1; f = 1;
        c_valid[0] = 1; c_rd[0] = 4; c_tag[0] = 0; c_data[0] = 32'h55; step();
        clear_in(); d_rs1[0] = 3; d_rs2[0] = 4; d_rs1[1] = 9; d_rs2[1] = 5; step();

        // Commit completing a pending register while it is read
        clear_in(); d_valid[0] = 1; d_rd[0] = 2; d_tag[0] = 5; step();
        clear_in(); c_valid[0] = 1; c_rd[0] = 2; c_tag[0] = 5; c_data[0] = 32'h11;
        d_rs1[0] = 2; d_rs2[1] = 2; step();
        clear_in(); d_rs1[0] = 2; step();

        // Writes to x0 have no effect
        clear_in(); d_valid[0] = 1; d_rd[0] = 0; d_tag[0] = 7;
        c_valid[0] = 1; c_rd[0] = 0; c_tag[0] = 0; c_data[0] = 32'hFF;
        d_rs2[0] = 0; d_rs1[1] = 0; step();
        clear_in(); d_rs1[0] = 0; d_rs2[1] = 0; step();

        // Asynchronous reset in the middle of renaming
        clear_in(); d_valid[0] = 1; d_rd[0] = 8; d_tag[0] = 9; d_valid[1] = 1; d_rd[1] = 10; d_tag[1] = 12; step();
        clear_in(); d_valid[0] = 1; d_rd[0] = 11; d_tag[0] = 13;
        d_rs1[0] = 9; d_rs2[0] = 4; d_rs1[1] = 8; d_rs2[1] = 2; rst = 1'b0; step();
        clear_in(); d_valid[0] = 1; d_rd[0] = 11; d_tag[0] = 14; d_rs1[1] = 8; d_rs2[1] = 11; step();
        rst = 1'b1;
        clear_in(); d_rs1[0] = 8; d_rs2[0] = 11; d_rs1[1] = 10; step();

        // Random traffic on a small register window to force collisions
        for (int it = 0; it < 400; it++) begin
            clear_in();
            for (int s = 0; s < DW; s++) begin
                d_valid[s] = 1'($urandom_range(0, 1));
                d_rs1[s]   = AW'($urandom_range(0, 7));
                d_rs2[s]   = AW'($urandom_range(0, 7));
                d_rd[s]    = AW'($urandom_range(0, 7));
                d_tag[s]   = TW'($urandom);
            end
            for (int k = 0; k < CW; k++) begin
                c_valid[k] = ($urandom_range(0, 2) != 0);
                c_rd[k]    = AW'($urandom_range(0, 7));
                c_tag[k]   = ($urandom_range(0, 3) != 0) ? m_tag[c_rd[k]] : TW'($urandom);
                c_data[k]  = $urandom;
            end
            f = ($urandom_range(0, 19) == 0);
            step();
        end

        clear_in();
        drive_bus();
        repeat (3) @(posedge clk);
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d queued lookups, expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
